hazard_unit: RTL
================

# hazard_unit

Stall, bubble and flush controller for the five-stage ARM pipeline, placed directly upstream of the ID-stage control multiplexer and the PC / IF-ID registers. It detects load-use hazards, branch redirects and data-memory wait, and drives `enable_pc`, `enable_ifid`, the NOP-insert select `S` and the IF/ID flush. It also produces the operand forwarding selects for the EX stage. A small FSM guarantees exactly one bubble per load-use hazard. Optional saturating counters record stall and flush events.

## Interface
- `CNT_W`, 16: width of the performance counters.
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `id_rn`, `id_rm`, `id_rd`  in  4 each  source registers of the instruction in ID (`id_rd` is the store data source).
- `id_use_rn`, `id_use_rm`, `id_use_rd`  in  1 each  the corresponding ID source is actually read.
- `id_branch_taken`  in  1  a branch or BL in ID resolves taken.
- `ex_rd`, `mem_rd`, `wb_rd`  in  4 each  destination register in EX, MEM and WB.
- `ex_rf_e`, `mem_rf_e`, `wb_rf_e`  in  1 each  register-file write enable in EX, MEM and WB.
- `ex_load`  in  1  the EX instruction is a load.
- `mem_wait`  in  1  data memory not ready; the whole pipeline freezes.
- `cnt_clr`  in  1  synchronous clear of the counters.
- `enable_pc`  out  1  PC load enable.
- `enable_ifid`  out  1  IF/ID load enable.
- `S`  out  1  1 forces all ID control signals to 0 (bubble into EX).
- `if_flush`  out  1  IF/ID loads 32'b0 on the next edge.
- `pipe_hold`  out  1  ID/EX, EX/MEM and MEM/WB hold their contents.
- `fwd_a`, `fwd_b`, `fwd_c`  out  2 each  operand source for Rn, Rm and Rd.
  - 00 = register file, 01 = EX result, 10 = MEM result, 11 = WB result.
- `stall_count`, `flush_count`  out  `CNT_W`  event counters.

## Operation
- FSM states:
  - RUN (reset state).
  - BUBBLE: one-cycle load-use bubble in flight.
- Hazard definitions:
  - `hz_src(r)`: the source is used and `ex_load` && `ex_rf_e` && `ex_rd == r`.
  - `lu`: `hz_src` holds for any of Rn, Rm or Rd, and the state is RUN.
- Priority, evaluated each cycle:
  1. `mem_wait`=1:
     - Outputs: `enable_pc`=0, `enable_ifid`=0, `pipe_hold`=1, `S`=0, `if_flush`=0.
     - State and counters hold.
  2. `lu`=1:
     - Outputs: `enable_pc`=0, `enable_ifid`=0, `S`=1, `if_flush`=0.
     - `id_branch_taken` is ignored this cycle.
     - Next state is BUBBLE; `stall_count`+1.
  3. `id_branch_taken`=1:
     - Outputs: `enable_pc`=1, `enable_ifid`=1, `if_flush`=1, `S`=0.
     - `flush_count`+1.
  4. Otherwise: `enable_pc`=1, `enable_ifid`=1, and all other control outputs 0.
- In BUBBLE, load-use detection is masked. The next state is RUN after one cycle, or the state stays BUBBLE while `mem_wait`=1. Branch and forwarding logic operate normally.
- Forwarding, per source `r`:
  - The first match wins, in the order EX (`ex_rf_e` && !`ex_load` && `ex_rd==r`), MEM (`mem_rf_e` && `mem_rd==r`), WB (`wb_rf_e` && `wb_rd==r`).
  - With no match, the select is 00.
  - If the source is unused, the select is 00.
- Counters saturate at all-ones and never wrap.
- `cnt_clr` has priority over increment.

## Timing
- All control and forward outputs are combinational from the inputs and the current state, with zero-cycle latency.
- FSM and counters update on the rising `clk` edge.
- Load-use costs exactly 1 bubble cycle. A taken branch costs exactly 1 flushed slot.
- While `reset`=0, the following are forced:
  - state RUN;
  - counters 0;
  - `enable_pc`=1, `enable_ifid`=1;
  - `S`, `if_flush`, `pipe_hold` = 0;
  - `fwd_*`=00.
- Reset asserted mid-BUBBLE returns the FSM to RUN immediately, with no residual bubble after release.
- Simultaneous `lu` and `id_branch_taken`: stall wins. The branch re-evaluates after the bubble.
- Simultaneous `mem_wait` and any hazard: freeze wins, and the hazard is re-evaluated when `mem_wait` drops.

## Configuration
- `HAZARD_PERF_CNT_EN` defined: `stall_count` and `flush_count` registers exist and respond to `cnt_clr`.
- Not defined:
  - Both counter outputs are tied to 0 and `cnt_clr` is ignored.
  - No counter flops are synthesized.
  - All other behaviour is identical.

## Test plan
- Load-use: `ex_load`=1, `ex_rf_e`=1, `ex_rd`=3, `id_rn`=3, `id_use_rn`=1 → `enable_pc`=0, `enable_ifid`=0, `S`=1 for exactly 1 cycle. Next cycle is BUBBLE, with the same inputs held → no stall; `stall_count`=1.
- Branch: `id_branch_taken`=1 with no hazard → `if_flush`=1, `enable_pc`=1, `S`=0; `flush_count`=1. Same cycle as load-use on Rm=5 → stall only, `flush_count` stays 0.
- Forwarding:
  - `ex_rd`=mem_rd=wb_rd=2, all `rf_e`=1, `ex_load`=0, `id_rn`=2 → `fwd_a`=01.
  - Drop `ex_rf_e` → 10.
  - Drop `mem_rf_e` → 11.
  - `id_use_rn`=0 → 00.
- `mem_wait`: hold `mem_wait`=1 for 3 cycles during BUBBLE → `pipe_hold`=1 throughout, state stays BUBBLE, counters unchanged. RUN resumes 1 cycle after release.
- Reset and saturation: assert `reset`=0 mid-BUBBLE → outputs take their reset values with no clock edge. Preload `stall_count` to 16'hFFFF, then one more stall → stays 16'hFFFF. `cnt_clr` → 0. Without `HAZARD_PERF_CNT_EN`, both counters read 0 throughout.

Source files
------------

// File: rtl/hazard_unit_if.sv
// hazard_unit_if: pipeline status in, stall/flush/forward controls out
// master: pipeline datapath, drives register ids and enables, reads controls
// slave : hazard_unit, reads pipeline status, drives controls
interface hazard_unit_if;
  logic [3:0] id_rn, id_rm, id_rd;
  logic       id_use_rn, id_use_rm, id_use_rd;
  logic       id_branch_taken;
  logic [3:0] ex_rd, mem_rd, wb_rd;
  logic       ex_rf_e, mem_rf_e, wb_rf_e;
  logic       ex_load;
  logic       mem_wait;
  logic       enable_pc, enable_ifid, S, if_flush, pipe_hold;
  logic [1:0] fwd_a, fwd_b, fwd_c;
  modport master (
    output id_rn, id_rm, id_rd, id_use_rn, id_use_rm, id_use_rd, id_branch_taken,
    output ex_rd, mem_rd, wb_rd, ex_rf_e, mem_rf_e, wb_rf_e, ex_load, mem_wait,
    input  enable_pc, enable_ifid, S, if_flush, pipe_hold, fwd_a, fwd_b, fwd_c
  );
  modport slave (
    input  id_rn, id_rm, id_rd, id_use_rn, id_use_rm, id_use_rd, id_branch_taken,
    input  ex_rd, mem_rd, wb_rd, ex_rf_e, mem_rf_e, wb_rf_e, ex_load, mem_wait,
    output enable_pc, enable_ifid, S, if_flush, pipe_hold, fwd_a, fwd_b, fwd_c
  );
endinterface

// File: rtl/hazard_unit.sv
// hazard_unit: load-use stall, branch flush, mem-wait freeze and EX operand forwarding
// clk, reset (async active-low), cnt_clr (sync counter clear)
// hz (slave): ID sources, EX/MEM/WB destinations, controls enable_pc/enable_ifid/S/if_flush/pipe_hold/fwd_*
// stall_count, flush_count: saturating event counters, present only with HAZARD_PERF_CNT_EN defined
module hazard_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cnt_clr,
  hazard_unit_if.slave     hz,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);
  localparam logic [0:0] RUN    = 1'b0;
  localparam logic [0:0] BUBBLE = 1'b1;

  logic [0:0] state, state_nxt;
  logic       ex_ld_w, ex_alu_w;
  logic       hz_rn, hz_rm, hz_rd;
  logic       lu, stall, flush;
  logic [1:0] sel_a, sel_b, sel_c;

  function automatic logic [1:0] fwd_sel(
    input logic       use_r,
    input logic [3:0] r,
    input logic       ex_ok,
    input logic [3:0] ex_rd,
    input logic       mem_ok,
    input logic [3:0] mem_rd,
    input logic       wb_ok,
    input logic [3:0] wb_rd
  );
    return !use_r                     ? 2'b00 :
           (ex_ok  && ex_rd  == r)    ? 2'b01 :
           (mem_ok && mem_rd == r)    ? 2'b10 :
           (wb_ok  && wb_rd  == r)    ? 2'b11 : 2'b00;
  endfunction

  // a load in EX cannot forward its result yet; an ALU op in EX can
  assign ex_ld_w  = hz.ex_load && hz.ex_rf_e;
  assign ex_alu_w = hz.ex_rf_e && !hz.ex_load;

  assign hz_rn = hz.id_use_rn && ex_ld_w && hz.ex_rd == hz.id_rn;
  assign hz_rm = hz.id_use_rm && ex_ld_w && hz.ex_rd == hz.id_rm;
  assign hz_rd = hz.id_use_rd && ex_ld_w && hz.ex_rd == hz.id_rd;

  // BUBBLE masks detection so each load-use costs exactly one bubble
  assign lu    = state == RUN && (hz_rn || hz_rm || hz_rd);
  assign stall = !hz.mem_wait && lu;
  assign flush = !hz.mem_wait && !lu && hz.id_branch_taken;

  assign sel_a = fwd_sel(hz.id_use_rn, hz.id_rn, ex_alu_w, hz.ex_rd, hz.mem_rf_e, hz.mem_rd, hz.wb_rf_e, hz.wb_rd);
  assign sel_b = fwd_sel(hz.id_use_rm, hz.id_rm, ex_alu_w, hz.ex_rd, hz.mem_rf_e, hz.mem_rd, hz.wb_rf_e, hz.wb_rd);
  assign sel_c = fwd_sel(hz.id_use_rd, hz.id_rd, ex_alu_w, hz.ex_rd, hz.mem_rf_e, hz.mem_rd, hz.wb_rf_e, hz.wb_rd);

  // outputs are gated by reset directly so they take reset values without a clock edge
  assign hz.enable_pc   = !reset || (!hz.mem_wait && !lu);
  assign hz.enable_ifid = !reset || (!hz.mem_wait && !lu);
  assign hz.S           = reset && stall;
  assign hz.if_flush    = reset && flush;
  assign hz.pipe_hold   = reset && hz.mem_wait;
  assign hz.fwd_a       = reset ? sel_a : 2'b00;
  assign hz.fwd_b       = reset ? sel_b : 2'b00;
  assign hz.fwd_c       = reset ? sel_c : 2'b00;

  always_comb state_nxt = hz.mem_wait ? state : (lu ? BUBBLE : RUN);

  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= RUN;
    else state <= state_nxt;

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else if (cnt_clr) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall && !(&stall_count)) stall_count <= stall_count + 1'b1;
      if (flush && !(&flush_count)) flush_count <= flush_count + 1'b1;
    end
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign stall_count    = '0;
  assign flush_count    = '0;
`endif
endmodule
